// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter.
// Holds the owner encoding of the in-flight read and the address/data
// width defaults shared with the core.
package mem_port_arbiter_pkg;

  // Width defaults shared with the core.
  localparam int unsigned DEF_DBITS    = 32;
  localparam int unsigned DEF_ADDRBITS = 16;
  localparam int unsigned DEF_WORDBITS = 2;

  // Streak counter width; large enough for any STARVE_LIMIT in 1..15.
  localparam int unsigned STREAKBITS = 4;

  // Who owns the read response due this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DR   = 2'b10
  } owner_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears to 0)
//   inc        : count enable
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = &count;

  // Count up on inc, hold once saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM (1-cycle read latency)
// between the fetch (if_*) and data (dm_*) requesters.
// Data wins contention unless fetch has lost STARVE_LIMIT grants in a row.
// Read data is routed back to whichever side owned the previous-cycle read;
// a flush suppresses a fetch response arriving in the same cycle.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   if_req/if_addr          : fetch request and byte address
//   if_gnt                  : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata      : fetch read response
//   dm_req/we/addr/wdata    : data request (we=1 store, 0 load)
//   dm_gnt                  : data accepted this cycle (combinational)
//   dm_rvalid/dm_rdata      : load read response
//   flush                   : redirect; kills pending and new fetch
//   ram_en/we/addr/wdata    : RAM command, ram_addr is a word index
//   ram_rdata               : RAM read data, valid the cycle after ram_en
//   conflict_cnt            : saturating count of cycles fetch lost
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DBITS        = DEF_DBITS,
  parameter int unsigned ADDRBITS     = DEF_ADDRBITS,
  parameter int unsigned WORDBITS     = DEF_WORDBITS,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNTBITS      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         if_req,
  input  logic [DBITS-1:0]             if_addr,
  output logic                         if_gnt,
  output logic                         if_rvalid,
  output logic [DBITS-1:0]             if_rdata,
  input  logic                         dm_req,
  input  logic                         dm_we,
  input  logic [DBITS-1:0]             dm_addr,
  input  logic [DBITS-1:0]             dm_wdata,
  output logic                         dm_gnt,
  output logic                         dm_rvalid,
  output logic [DBITS-1:0]             dm_rdata,
  input  logic                         flush,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [ADDRBITS-WORDBITS-1:0] ram_addr,
  output logic [DBITS-1:0]             ram_wdata,
  input  logic [DBITS-1:0]             ram_rdata,
  output logic [CNTBITS-1:0]           conflict_cnt
);

  localparam logic [STREAKBITS-1:0] STREAK_MAX = STREAKBITS'(STARVE_LIMIT);

  owner_t                owner_q;
  owner_t                owner_d;
  logic [STREAKBITS-1:0] streak_q;
  logic [STREAKBITS-1:0] streak_d;
  logic                  force_if;
  logic                  lost_fetch;
  logic                  unused_addr_bits;

  // Address bits outside the RAM window and the byte offset are don't-care.
  assign unused_addr_bits = ^{if_addr, dm_addr};

  assign force_if = (streak_q == STREAK_MAX);

  // Arbitration: data first, fetch forced through after a losing streak.
  // Nothing is granted while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      if_gnt = if_req & ~flush & (~dm_req | force_if);
      dm_gnt = dm_req & ~if_gnt;
    end
  end

  // RAM command from the winner.
  assign ram_en    = if_gnt | dm_gnt;
  assign ram_we    = dm_gnt & dm_we;
  assign ram_wdata = dm_wdata;
  assign ram_addr  = if_gnt ? if_addr[ADDRBITS-1:WORDBITS]
                            : dm_addr[ADDRBITS-1:WORDBITS];

  // Response routing from last cycle's owner.
  assign dm_rvalid = (owner_q == OWN_DR);
  assign if_rvalid = (owner_q == OWN_IF) & ~flush;
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;

  // Fetch lost this cycle; a flushed fetch is not a loss.
  assign lost_fetch = if_req & ~if_gnt & ~flush;

  // Next owner and starvation streak.
  always_comb begin
    owner_d  = OWN_NONE;
    streak_d = streak_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      owner_d = OWN_DR;
    end
    if (flush || !if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAKBITS'(1);
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  sat_counter #(
    .WIDTH (CNTBITS)
  ) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lost_fetch),
    .count (conflict_cnt)
  );

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written reset and counter-saturation sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] DA = 32'h1111_0000;
  localparam logic [31:0] DB = 32'h2222_0001;
  localparam logic [31:0] DD = 32'hDEAD_BEEF;
  localparam int NV = 33;

  logic        clk;
  logic        reset;
  logic        preload;
  logic        if_req, dm_req, dm_we, flush;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] conflict_cnt;

  // Second instance with a narrow counter for saturation.
  logic        reset2, if_req2, dm_req2;
  logic        if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2;
  logic [31:0] if_rdata2, dm_rdata2, ram_wdata2;
  logic        ram_en2, ram_we2;
  logic [13:0] ram_addr2;
  logic [3:0]  conflict_cnt2;

  int total;
  int bad;

  logic [31:0] mem [0:16383];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .flush(flush),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.CNTBITS(4)) dut2 (
    .clk(clk), .reset(reset2),
    .if_req(if_req2), .if_addr(32'h100), .if_gnt(if_gnt2),
    .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .dm_req(dm_req2), .dm_we(1'b0), .dm_addr(32'h2000), .dm_wdata(32'h0),
    .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
    .flush(1'b0),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2),
    .ram_wdata(ram_wdata2), .ram_rdata(32'h0),
    .conflict_cnt(conflict_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      mem[14'h040] <= DA;
      mem[14'h041] <= DB;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        fl;
    logic        egi;
    logic        egd;
    logic        eri;
    logic        erd;
    logic        een;
    logic        ewe;
    logic [13:0] eadr;
    logic [31:0] erdat;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dwd, logic fl,
                              logic egi, logic egd, logic eri, logic erd,
                              logic een, logic ewe, logic [13:0] eadr,
                              logic [31:0] erdat, logic [15:0] ecnt);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.fl = fl; v.egi = egi; v.egd = egd; v.eri = eri; v.erd = erd;
    v.een = een; v.ewe = ewe; v.eadr = eadr; v.erdat = erdat; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; flush = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; preload = 1'b1;
    reset2 = 1'b1; if_req2 = 1'b0; dm_req2 = 1'b0;
    idle_inputs();

    // Stimulus/expectation table, one entry per clock.
    //           ir ia      dr dw da       dwd fl  gi gd ri rd en we adr     rdat cnt
    vt[0]  = mk(1, 32'h100, 0, 0, 0,       0,  0,  1, 0, 0, 0, 1, 0, 14'h40, 0,  0);
    vt[1]  = mk(1, 32'h104, 0, 0, 0,       0,  0,  1, 0, 1, 0, 1, 0, 14'h41, DA, 0);
    vt[2]  = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 1, 0, 0, 0, 0,      DB, 0);
    vt[3]  = mk(0, 0,       1, 1, 32'h2000, DD, 0, 0, 1, 0, 0, 1, 1, 14'h800, 0, 0);
    vt[4]  = mk(0, 0,       1, 0, 32'h2000, 0, 0,  0, 1, 0, 0, 1, 0, 14'h800, 0, 0);
    vt[5]  = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 0, 1, 0, 0, 0,      DD, 0);
    vt[6]  = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 0, 1, 0, 14'h800, 0, 0);
    vt[7]  = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 1);
    vt[8]  = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 2);
    vt[9]  = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 3);
    vt[10] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  1, 0, 0, 1, 1, 0, 14'h40,  DD, 4);
    vt[11] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 1, 0, 1, 0, 14'h800, DA, 4);
    vt[12] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 5);
    vt[13] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 6);
    vt[14] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 7);
    vt[15] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  1, 0, 0, 1, 1, 0, 14'h40,  DD, 8);
    vt[16] = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 1, 0, 0, 0, 0,      DA, 8);
    vt[17] = mk(1, 32'h104, 0, 0, 0,       0,  0,  1, 0, 0, 0, 1, 0, 14'h41, 0,  8);
    vt[18] = mk(1, 32'h100, 0, 0, 0,       0,  1,  0, 0, 0, 0, 0, 0, 0,      0,  8);
    vt[19] = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 0, 0, 0, 0, 0,      0,  8);
    vt[20] = mk(0, 0,       1, 0, 32'h2000, 0, 0,  0, 1, 0, 0, 1, 0, 14'h800, 0, 8);
    vt[21] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 1,  0, 1, 0, 1, 1, 0, 14'h800, DD, 8);
    vt[22] = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 0, 1, 0, 0, 0,      DD, 8);
    vt[23] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 0, 1, 0, 14'h800, 0, 8);
    vt[24] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 9);
    vt[25] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 10);
    vt[26] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 1,  0, 1, 0, 1, 1, 0, 14'h800, DD, 11);
    vt[27] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 11);
    vt[28] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 12);
    vt[29] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 13);
    vt[30] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  0, 1, 0, 1, 1, 0, 14'h800, DD, 14);
    vt[31] = mk(1, 32'h100, 1, 0, 32'h2000, 0, 0,  1, 0, 0, 1, 1, 0, 14'h40,  DD, 15);
    vt[32] = mk(0, 0,       0, 0, 0,       0,  0,  0, 0, 1, 0, 0, 0, 0,      DA, 15);

    // Reset state with both sides requesting: no grants, no responses.
    repeat (2) @(posedge clk);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h2000;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    preload = 1'b0;

    // Per-cycle vector table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_req = vt[i].ir; if_addr = vt[i].ia; dm_req = vt[i].dr;
      dm_we = vt[i].dw; dm_addr = vt[i].da; dm_wdata = vt[i].dwd;
      flush = vt[i].fl;
      #1;
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vt[i].egi));
      chk($sformatf("v%0d_dm_gnt", i), 32'(dm_gnt), 32'(vt[i].egd));
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vt[i].eri));
      chk($sformatf("v%0d_dm_rvalid", i), 32'(dm_rvalid), 32'(vt[i].erd));
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vt[i].een));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].ewe));
      chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vt[i].ecnt));
      if (vt[i].een)
        chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].eadr));
      if (vt[i].ewe)
        chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].dwd);
      if (vt[i].eri)
        chk($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].erdat);
      if (vt[i].erd)
        chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vt[i].erdat);
    end

    // Reset asserted the cycle after a load grant: response is dropped.
    @(negedge clk);
    idle_inputs();
    dm_req = 1'b1; dm_addr = 32'h2000;
    #1;
    chk("rm_load_gnt", 32'(dm_gnt), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rm_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("rm_cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm_dm_rvalid_after", 32'(dm_rvalid), 32'h0);
    @(negedge clk);
    #1;
    chk("rm_dm_rvalid_next", 32'(dm_rvalid), 32'h0);

    // Narrow counter saturates under continuous contention.
    @(negedge clk);
    reset2 = 1'b0; if_req2 = 1'b1; dm_req2 = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("sat_cnt_15cyc", 32'(conflict_cnt2), 32'hC);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_cnt_25cyc", 32'(conflict_cnt2), 32'hF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_cnt_hold", 32'(conflict_cnt2), 32'hF);
    if_req2 = 1'b0; dm_req2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency) between the instruction-fetch (FE) requester and the data (MEM-stage LW/SW) requester of the 5-stage core. Data accesses have priority because they belong to the older instruction. A streak counter stops fetch from starving. Read responses are routed back to the owner, a flush kills stale fetch responses, and a saturating counter records fetch-lost cycles for performance debug.

Parameters:
DBITS, 32, data word width
ADDRBITS, 16, byte-address bits decoded to RAM
WORDBITS, 2, byte-offset bits dropped to form the word index
STARVE_LIMIT, 4, consecutive contended data grants before fetch is forced through (1..15)
CNTBITS, 16, width of the conflict counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
if_req  in  1  fetch request
if_addr  in  DBITS  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch data valid this cycle
if_rdata  out  DBITS  fetch data
dm_req  in  1  data request
dm_we  in  1  1 = store, 0 = load
dm_addr  in  DBITS  data byte address
dm_wdata  in  DBITS  store data
dm_gnt  out  1  data accepted this cycle (combinational)
dm_rvalid  out  1  load data valid this cycle
dm_rdata  out  DBITS  load data
flush  in  1  branch/jump redirect; kills pending fetch
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDRBITS-WORDBITS  RAM word index
ram_wdata  out  DBITS  RAM write data
ram_rdata  in  DBITS  RAM read data, valid the cycle after ram_en
conflict_cnt  out  CNTBITS  saturating count of cycles where fetch lost

Behaviour:
- Reset: owner_q=NONE, streak_q=0, conflict_cnt=0. All gnt and rvalid outputs are 0 while reset is high. Any access in flight is dropped with no response.
- Arbitration is combinational each cycle:
  - force_if = (streak_q == STARVE_LIMIT).
  - If flush=1, if_gnt=0.
  - Otherwise, with both requesting: dm wins unless force_if.
  - A single requester always wins.
- ram_en = if_gnt | dm_gnt. ram_we = dm_gnt & dm_we. ram_wdata = dm_wdata.
- ram_addr = winner address bits [ADDRBITS-1:WORDBITS]. Upper address bits are ignored; MMIO decode is upstream.
- owner_q register, next value: IF if if_gnt; DR if dm_gnt & ~dm_we; NONE otherwise, including stores.
- Responses (combinational from owner_q):
  - dm_rvalid = (owner_q==DR).
  - if_rvalid = (owner_q==IF) & ~flush.
  - if_rdata = dm_rdata = ram_rdata.
  - Latency is exactly 1 cycle from grant to rvalid.
  - A store completes at grant and has no response.
- Back-to-back grants are allowed every cycle. Throughput is 1 access per cycle.
- Requesters hold req/addr/we/wdata stable until gnt. The arbiter does not latch requests.
- streak_q:
  - Increments when dm_gnt & if_req & ~flush.
  - Clears to 0 when if_gnt, when if_req=0, or when flush=1.
  - Never exceeds STARVE_LIMIT.
- conflict_cnt increments when if_req & ~if_gnt & ~flush. It saturates at all-ones and is cleared only by reset.
- Flush in the same cycle as a fetch response: the response is suppressed, and a dm response in that cycle is unaffected. Flush with dm_req: dm is still granted.
- Reset mid-operation: the response due next cycle is not delivered.

Decomposition:
- Shared package holds:
  - owner encoding: NONE=2'b00, IF=2'b01, DR=2'b10;
  - DBITS/ADDRBITS/WORDBITS defaults shared with the core.
- One natural sub-module: sat_counter (parameterized width, inc, reset), used for conflict_cnt.
- Arbitration and routing stay in the top module.

Test Plan:
- Fetch only, if_req=1, if_addr=0x100, 0x104 on consecutive cycles (RAM preloaded) -> if_gnt=1 both cycles, ram_addr=0x40,0x41, if_rvalid the following cycles with matching data, conflict_cnt=0.
- Store then load: dm_we=1 addr 0x2000 wdata 0xDEADBEEF, next cycle dm_we=0 same addr -> ram_we=1 then 0, dm_rvalid one cycle later with 0xDEADBEEF.
- Continuous contention, STARVE_LIMIT=4, both req held -> grant pattern dm,dm,dm,dm,if repeating; conflict_cnt=4 after the first 5 cycles.
- Fetch granted at cycle N, flush=1 at N+1 -> if_rvalid=0 at N+1, if_gnt=0 at N+1, streak_q=0.
- Load granted at N, flush at N+1 -> dm_rvalid=1 at N+1 with correct data.
- Reset asserted the cycle after a load grant -> no dm_rvalid, conflict_cnt=0, owner_q=NONE; CNTBITS=4 with 20 lost cycles -> conflict_cnt=0xF.
